// File: rtl/spi_pkg.sv
// Shared types and constants for the sysClk-domain SPI target.
// Optional feature macro: SPI_TARGET_RX_OVERRUN_EN (see spi_target_sync).
package spi_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } spi_state_t;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detect on the synced level.
// The reset level is a parameter so an idle pin never fakes an edge.
module spi_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the async pin through the chain and keep a delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_target_sync.sv
// SPI mode-0 target oversampled entirely in the sysClk domain.
// Macro SPI_TARGET_RX_OVERRUN_EN enables sticky rx overrun detection.
module spi_target_sync
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_byte,
  input  logic                  tx_load,
  output logic                  tx_pending,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  rx_overrun,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

  spi_state_t state;
  spi_state_t state_nxt;

  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_s;
  logic cs_rise;
  logic cs_fall;

  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_s;

  logic [DATA_WIDTH-1:0] shadow;
  logic [DATA_WIDTH-1:0] shift_tx;
  logic [DATA_WIDTH-1:0] shift_rx;
  logic [CW-1:0]         bit_cnt;
  logic                  done;
  logic                  consume;
  logic                  commit;

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .INIT   (1'b0)
  ) u_sclk (
    .clk   (sysClk),
    .rst_n (reset),
    .din   (sclk),
    .sync  (sclk_s),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES (SYNC_STAGES),
    .INIT   (1'b1)
  ) u_cs (
    .clk   (sysClk),
    .rst_n (reset),
    .din   (cs_n),
    .sync  (cs_s),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // MOSI matches SCLK depth so data lines up with the detected rise.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // State register.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: select starts a frame, deselect aborts from anywhere.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: drive the pad and report busy only while selected.
  always_comb begin
    miso_oe = 1'b0;
    busy    = 1'b0;
    if (state == SHIFT) begin
      miso_oe = 1'b1;
      busy    = 1'b1;
    end
  end

  // Shadow is taken at select and at each frame boundary.
  assign consume = ((state == IDLE) && cs_fall) ||
                   ((state == SHIFT) && !cs_rise &&
                    sclk_fall && (bit_cnt == FULL));

  // A finished byte is dropped if deselect lands on the commit cycle.
  assign commit = done && !cs_rise;

  // Host-side tx shadow; a same-cycle load wins over consumption.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      shadow     <= '0;
      tx_pending <= 1'b0;
    end else if (tx_load) begin
      shadow     <= tx_byte;
      tx_pending <= 1'b1;
    end else if (consume) begin
      tx_pending <= 1'b0;
    end
  end

  // Shift engine: sample on sclk rise, launch next bit on sclk fall.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      shift_tx <= '0;
      shift_rx <= '0;
      miso     <= 1'b0;
      bit_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) begin
          shift_tx <= shadow;
          miso     <= shadow[DATA_WIDTH-1];
          bit_cnt  <= '0;
        end
      end else if (cs_rise) begin
        miso    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (sclk_rise) begin
          shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 1'b1;
          done     <= (bit_cnt == LAST);
        end
        if (sclk_fall) begin
          if (bit_cnt == FULL) begin
            shift_tx <= shadow;
            miso     <= shadow[DATA_WIDTH-1];
            bit_cnt  <= '0;
          end else begin
            shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
            miso     <= shift_tx[DATA_WIDTH-2];
          end
        end
      end
    end
  end

  // Receive holding register with valid/ack handshake.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else if (commit) begin
      rx_byte  <= shift_rx;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef SPI_TARGET_RX_OVERRUN_EN
  // Sticky overrun: set on unacked overwrite, cleared by a spare ack.
  always_ff @(posedge sysClk or negedge reset) begin
    if (!reset) begin
      rx_overrun <= 1'b0;
    end else if (commit && rx_valid && !rx_ack) begin
      rx_overrun <= 1'b1;
    end else if (rx_ack && !rx_valid) begin
      rx_overrun <= 1'b0;
    end
  end
`else
  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target_sync.sv
// Directed bench for spi_target_sync: 50 MHz sysClk, 2 MHz SPI master.
// Overrun expectations follow SPI_TARGET_RX_OVERRUN_EN.
module tb_spi_target_sync;

  logic       sysClk;
  logic       reset;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       tx_pending;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       busy;

  int         checks;
  int         errors;
  logic [7:0] mi;
  logic       ovr_exp;

  spi_target_sync dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .tx_pending (tx_pending),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .busy       (busy)
  );

  initial begin
    sysClk = 1'b0;
    forever #10 sysClk = ~sysClk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int hi,
                          input int lo);
    for (int i = hi; i >= lo; i--) begin
      mosi = mo[i];
      #250 sclk = 1'b1;
      mi[i] = miso;
      #250 sclk = 1'b0;
    end
  endtask

  task automatic load(input logic [7:0] v);
    tx_byte = v;
    tx_load = 1'b1;
    #20 tx_load = 1'b0;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    #20 rx_ack = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_oe"}, miso_oe, 0);
    chk({tag, "_pend"}, tx_pending, 0);
    chk({tag, "_rxb"}, rx_byte, 0);
    chk({tag, "_rxv"}, rx_valid, 0);
    chk({tag, "_ovr"}, rx_overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    mi      = 8'h00;
    reset   = 1'b0;
    sclk    = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    tx_byte = 8'h00;
    tx_load = 1'b0;
    rx_ack  = 1'b0;
`ifdef SPI_TARGET_RX_OVERRUN_EN
    ovr_exp = 1'b1;
`else
    ovr_exp = 1'b0;
`endif
    #3;
    #60;
    chk_reset_outs("rst");
    reset = 1'b1;
    #100;

    // 1: single frame
    load(8'hA5);
    chk("t1_pend_load", tx_pending, 1);
    cs_n = 1'b0;
    #200;
    chk("t1_pend_cs", tx_pending, 0);
    chk("t1_oe", miso_oe, 1);
    chk("t1_busy", busy, 1);
    spi_bits(8'h3C, 7, 0);
    chk("t1_miso", mi, 8'hA5);
    #200;
    chk("t1_rxv", rx_valid, 1);
    chk("t1_rxb", rx_byte, 8'h3C);
    cs_n = 1'b1;
    #200;
    chk("t1_idle_oe", miso_oe, 0);
    chk("t1_idle_busy", busy, 0);
    ack();
    chk("t1_ack", rx_valid, 0);

    // 2: back-to-back frames, reload mid-frame
    load(8'h81);
    cs_n = 1'b0;
    #200;
    spi_bits(8'h12, 7, 4);
    load(8'h7E);
    chk("t2_pend_mid", tx_pending, 1);
    spi_bits(8'h12, 3, 0);
    chk("t2_miso1", mi, 8'h81);
    #200;
    chk("t2_rxv1", rx_valid, 1);
    chk("t2_rxb1", rx_byte, 8'h12);
    chk("t2_pend_used", tx_pending, 0);
    ack();
    chk("t2_ack1", rx_valid, 0);
    spi_bits(8'h34, 7, 0);
    chk("t2_miso2", mi, 8'h7E);
    #200;
    chk("t2_rxv2", rx_valid, 1);
    chk("t2_rxb2", rx_byte, 8'h34);
    ack();
    cs_n = 1'b1;
    #200;

    // 3: abort after 5 bits, then a clean frame
    cs_n = 1'b0;
    #200;
    spi_bits(8'hFF, 7, 3);
    cs_n = 1'b1;
    #200;
    chk("t3_busy", busy, 0);
    chk("t3_oe", miso_oe, 0);
    chk("t3_miso", miso, 0);
    chk("t3_rxv", rx_valid, 0);
    cs_n = 1'b0;
    #200;
    spi_bits(8'hF0, 7, 0);
    chk("t3_retx", mi, 8'h7E);
    #200;
    chk("t3_rxb", rx_byte, 8'hF0);
    chk("t3_rxv2", rx_valid, 1);
    ack();
    cs_n = 1'b1;
    #200;

    // 4: shadow retransmitted without reload
    load(8'h55);
    cs_n = 1'b0;
    #200;
    spi_bits(8'h00, 7, 0);
    chk("t4_miso1", mi, 8'h55);
    #200;
    ack();
    cs_n = 1'b1;
    #200;
    cs_n = 1'b0;
    #200;
    spi_bits(8'h00, 7, 0);
    chk("t4_miso2", mi, 8'h55);
    chk("t4_pend", tx_pending, 0);
    #200;
    ack();
    cs_n = 1'b1;
    #200;

    // 5: two frames without ack
    cs_n = 1'b0;
    #200;
    spi_bits(8'h11, 7, 0);
    #200;
    chk("t5_ovr0", rx_overrun, 0);
    spi_bits(8'h22, 7, 0);
    #200;
    cs_n = 1'b1;
    #200;
    chk("t5_rxb", rx_byte, 8'h22);
    chk("t5_rxv", rx_valid, 1);
    chk("t5_ovr", rx_overrun, ovr_exp);
    ack();
    chk("t5_ack", rx_valid, 0);
    chk("t5_sticky", rx_overrun, ovr_exp);
    ack();
    chk("t5_clr", rx_overrun, 0);

    // 6: async reset mid-frame
    cs_n = 1'b0;
    #200;
    spi_bits(8'hC3, 7, 4);
    reset = 1'b0;
    #1;
    chk_reset_outs("t6");
    cs_n = 1'b1;
    #9;
    #40;
    reset = 1'b1;
    #100;
    cs_n = 1'b0;
    #200;
    spi_bits(8'h99, 7, 0);
    chk("t6_miso", mi, 8'h00);
    #200;
    chk("t6_rxv", rx_valid, 1);
    chk("t6_rxb", rx_byte, 8'h99);
    ack();
    cs_n = 1'b1;
    #200;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
